// File: rtl/round_key_inv.sv
// round_key_inv -- inverse AES-256 key-schedule step.
//
// Takes eight consecutive expanded-key words w[8r..8r+7] and the round index r,
// and recovers the previous eight words w[8r-8..8r-1]. Two-stage pipeline:
// stage 1 recovers the upper four words, stage 2 the lower four (which depend
// on the recovered w[8r-1]).
//
// Optional build macro: ROUND_KEY_INV_SINGLE_STAGE_EN
//   defined   -> stage-1 register removed, 1-cycle latency, depth-1 buffering
//   undefined -> two-stage pipeline, 2-cycle latency
//
// Ports:
//   clk_i      clock, rising edge
//   reset_n_i  asynchronous active-low reset
//   k          [0:255] words w[8r..8r+7], word j at k[32j +: 32], MSB byte first
//   r          [0:3]   round index of k, legal 1..7
//   v_i        k/r valid
//   ready_o    block can accept (transfer on v_i & ready_o)
//   result     [0:255] words w[8r-8..8r-1], same layout as k
//   v_o        result valid
//   yumi_i     consumer takes result (only while v_o)

// AES forward S-box applied to N bytes independently. The S-box is computed
// as the GF(2^8) multiplicative inverse (x^254) followed by the affine map.
module sub_bytes #(
  parameter int unsigned N = 4
) (
  input  logic [8*N-1:0] x,
  output logic [8*N-1:0] y
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] s;
    p = '0;
    s = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ s;
      s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 = x^(2+4+...+128); zero maps to zero without a special case.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = b;
    inv = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  for (genvar i = 0; i < N; i++) begin : g_byte
    assign y[8*i +: 8] = sbox(x[8*i +: 8]);
  end

endmodule

module round_key_inv (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic [0:255] k,
  input  logic [0:3]   r,
  input  logic         v_i,
  output logic         ready_o,
  output logic [0:255] result,
  output logic         v_o,
  input  logic         yumi_i
);

  logic [0:7][31:0] in_w;
  logic [0:3][31:0] hi_c;
  logic [0:3][31:0] lo_c;
  logic [31:0]      sub_hi;
  logic [31:0]      sub_lo;
  logic [31:0]      rot_w;
  logic [31:0]      rcon;

  // Stage-2 operands: registered stage-1 data, or stage-1 logic directly.
  logic [0:3][31:0] s2_hi;
  logic [0:3][31:0] s2_lo;
  logic [3:0]       s2_r;
  logic             s2_v_in;
  logic             s2_en;

  assign in_w = k;

  // Upper half: out[4] = in[4] ^ Sub(in[3]); out[4+m] = in[4+m] ^ in[3+m].
  sub_bytes #(.N(4)) u_sub_hi (.x(in_w[3]), .y(sub_hi));

  always_comb begin
    hi_c[0] = in_w[4] ^ sub_hi;
    hi_c[1] = in_w[5] ^ in_w[4];
    hi_c[2] = in_w[6] ^ in_w[5];
    hi_c[3] = in_w[7] ^ in_w[6];
  end

  assign s2_en = !v_o | yumi_i;

`ifdef ROUND_KEY_INV_SINGLE_STAGE_EN
  assign ready_o = s2_en;
  assign s2_v_in = v_i;
  assign s2_hi   = hi_c;
  assign s2_lo   = in_w[0:3];
  assign s2_r    = r;
`else
  logic             s1_v;
  logic             s1_en;
  logic [0:3][31:0] s1_hi;
  logic [0:3][31:0] s1_lo;
  logic [3:0]       s1_r;

  assign s1_en   = !s1_v | s2_en;
  assign ready_o = s1_en;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s1_v  <= 1'b0;
      s1_hi <= '0;
      s1_lo <= '0;
      s1_r  <= '0;
    end else if (s1_en) begin
      s1_v <= v_i;
      if (v_i) begin
        s1_hi <= hi_c;
        s1_lo <= in_w[0:3];
        s1_r  <= r;
      end
    end
  end

  assign s2_v_in = s1_v;
  assign s2_hi   = s1_hi;
  assign s2_lo   = s1_lo;
  assign s2_r    = s1_r;
`endif

  // Lower half: out[0] = in[0] ^ Sub(Rot(out[7])) ^ Rcon; out[m] = in[m] ^ in[m-1].
  assign rot_w = {s2_hi[3][23:0], s2_hi[3][31:24]};
  assign rcon  = 32'h0100_0000 << (s2_r - 4'd1);

  sub_bytes #(.N(4)) u_sub_lo (.x(rot_w), .y(sub_lo));

  always_comb begin
    lo_c[0] = s2_lo[0] ^ sub_lo ^ rcon;
    lo_c[1] = s2_lo[1] ^ s2_lo[0];
    lo_c[2] = s2_lo[2] ^ s2_lo[1];
    lo_c[3] = s2_lo[3] ^ s2_lo[2];
  end

  // result only reloads when a valid word enters stage 2, so it stays stable
  // through bubbles as well as stalls.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_o    <= 1'b0;
      result <= '0;
    end else if (s2_en) begin
      v_o <= s2_v_in;
      if (s2_v_in) result <= {lo_c, s2_hi};
    end
  end

endmodule

// File: tb/tb_round_key_inv.sv
// tb_round_key_inv -- self-checking bench for round_key_inv.
// Expected results come from a table-based forward AES-256 key-schedule step:
// random previous words w are stepped forward, the forward output is fed to the
// DUT, and w is pushed to a scoreboard queue for comparison on output.
module tb_round_key_inv;

`ifdef ROUND_KEY_INV_SINGLE_STAGE_EN
  localparam int LAT   = 1;
  localparam int DEPTH = 1;
`else
  localparam int LAT   = 2;
  localparam int DEPTH = 2;
`endif

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [255:0] KV  =
    256'ha573c29f_a176c498_a97fce93_a572c09c_1651a8cd_0244beda_1a5da4c1_0640bade;
  localparam logic [255:0] KEY =
    256'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617_18191a1b_1c1d1e1f;

  logic         clk_i = 1'b0;
  logic         reset_n_i;
  logic [0:255] k;
  logic [0:3]   r;
  logic         v_i;
  logic         ready_o;
  logic [0:255] result;
  logic         v_o;
  logic         yumi_i;

  always #5 clk_i = ~clk_i;

  round_key_inv dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .k         (k),
    .r         (r),
    .v_i       (v_i),
    .ready_o   (ready_o),
    .result    (result),
    .v_o       (v_o),
    .yumi_i    (yumi_i)
  );

  typedef struct {
    logic [255:0] val;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   errors  = 0;
  int   checks  = 0;
  int   cyc     = 0;
  int   n_in    = 0;
  int   n_out   = 0;
  bit   chk_lat = 1'b0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sub4(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 4; i++) y[8*i +: 8] = SBOX[8*x[8*i +: 8] +: 8];
    return y;
  endfunction

  // Forward AES-256 schedule step: w[8r-8..8r-1] -> w[8r..8r+7].
  function automatic logic [255:0] fwd(input logic [255:0] a, input int rr);
    logic [31:0]  aw [8];
    logic [31:0]  bw [8];
    logic [31:0]  t;
    logic [255:0] o;
    for (int i = 0; i < 8; i++) aw[i] = a[255-32*i -: 32];
    t = {aw[7][23:0], aw[7][31:24]};
    bw[0] = aw[0] ^ sub4(t) ^ (32'h0100_0000 << (rr - 1));
    for (int i = 1; i < 8; i++) bw[i] = aw[i] ^ ((i == 4) ? sub4(bw[3]) : bw[i-1]);
    for (int i = 0; i < 8; i++) o[255-32*i -: 32] = bw[i];
    return o;
  endfunction

  function automatic logic [255:0] rand256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One clock cycle: drive at negedge, sample just before the posedge.
  task automatic step(input logic v, input logic [255:0] kk, input int rr,
                      input logic [255:0] exp, input logic y, output logic acc);
    exp_t e;
    @(negedge clk_i);
    v_i    = v;
    k      = kk;
    r      = rr[3:0];
    yumi_i = y & v_o;
    #4;
    acc = v_i & ready_o;
    if (v_o && yumi_i) begin
      n_out++;
      check("output_expected", q.size() != 0, 1'b1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("result", result, e.val);
        if (chk_lat) check("latency", cyc - e.cyc, LAT);
      end
    end
    if (acc) begin
      q.push_back('{exp, cyc});
      n_in++;
    end
    @(posedge clk_i);
    cyc++;
  endtask

  task automatic drain(input string tag);
    logic acc;
    for (int i = 0; i < 40 && q.size() != 0; i++) step(1'b0, '0, 1, '0, 1'b1, acc);
    check(tag, q.size(), 0);
    step(1'b0, '0, 1, '0, 1'b1, acc);
    step(1'b0, '0, 1, '0, 1'b1, acc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic         acc;
    logic [255:0] w;
    int           rr;
    logic [255:0] bp_w [3];
    int           idx;

    reset_n_i = 1'b0;
    v_i       = 1'b0;
    k         = '0;
    r         = '0;
    yumi_i    = 1'b0;

    // Reset state
    repeat (2) @(negedge clk_i);
    check("reset_v_o", v_o, 1'b0);
    check("reset_ready", ready_o, 1'b1);
    check("reset_result", result, '0);
    reset_n_i = 1'b1;

    // Known vector
    chk_lat = 1'b1;
    step(1'b1, KV, 1, KEY, 1'b1, acc);
    check("kv_accept", acc, 1'b1);
    drain("kv_drain");

    // Round trip r=1..7 then streaming with random r, yumi held high
    for (int i = 0; i < 23; i++) begin
      rr = (i < 7) ? i + 1 : int'($urandom_range(1, 7));
      w  = rand256();
      step(1'b1, fwd(w, rr), rr, w, 1'b1, acc);
      check("stream_ready", acc, 1'b1);
    end
    drain("stream_drain");

    // Back-pressure
    chk_lat = 1'b0;
    for (int i = 0; i < 3; i++) bp_w[i] = rand256();
    idx = 0;
    for (int i = 0; i < 5; i++) begin
      if (idx < 3) step(1'b1, fwd(bp_w[idx], 3), 3, bp_w[idx], 1'b0, acc);
      else         step(1'b0, '0, 3, '0, 1'b0, acc);
      if (acc) idx++;
      #1;
      if (i >= DEPTH - 1) begin
        check("bp_ready_low", ready_o, 1'b0);
        check("bp_v_o", v_o, 1'b1);
        check("bp_hold", result, (q.size() != 0) ? q[0].val : {256{1'bx}});
      end
    end
    check("bp_accepted", idx, DEPTH);
    for (int i = 0; i < 20 && idx < 3; i++) begin
      step(1'b1, fwd(bp_w[idx], 3), 3, bp_w[idx], 1'b1, acc);
      if (acc) idx++;
    end
    check("bp_all_accepted", idx, 3);
    drain("bp_drain");
    check("no_loss_dup", n_out, n_in);

    // Reset mid-flight
    w = rand256();
    step(1'b1, fwd(w, 5), 5, w, 1'b0, acc);
    w = rand256();
    step(1'b1, fwd(w, 6), 6, w, 1'b0, acc);
    @(negedge clk_i);
    v_i       = 1'b0;
    yumi_i    = 1'b0;
    reset_n_i = 1'b0;
    #1;
    check("mid_reset_v_o", v_o, 1'b0);
    check("mid_reset_result", result, '0);
    check("mid_reset_ready", ready_o, 1'b1);
    q.delete();
    @(negedge clk_i);
    reset_n_i = 1'b1;
    chk_lat = 1'b1;
    step(1'b1, KV, 1, KEY, 1'b1, acc);
    check("post_reset_accept", acc, 1'b1);
    drain("post_reset_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/round_key_inv.md
# round_key_inv

Inverse AES-256 key-schedule step, the reverse of the forward round-key block. It takes eight consecutive expanded-key words w[8r..8r+7] plus the round index r and recovers the previous eight words w[8r-8..8r-1]. The decryption datapath uses it to walk the key schedule backwards on the fly, starting from the final round keys. It is a two-stage pipeline with a full valid/ready input handshake and a valid/yumi output handshake.

## Interface
- No parameters.
- clk_i  input  1  clock; all state updates on rising edge.
- reset_n_i  input  1  asynchronous, active-low reset.
- k  input  [0:255]  words w[8r..8r+7]; word j is at bits [32j +: 32]; byte 0 of each word is its MSBs.
- r  input  [0:3]  round index of k, legal range 1..7.
- v_i  input  1  k and r valid.
- ready_o  output  1  block can accept; a transfer happens when v_i & ready_o.
- result  output logic [0:255]  words w[8r-8..8r-1], same word/bit layout as k.
- v_o  output logic  1  result valid.
- yumi_i  input  1  consumer takes result; asserted only while v_o=1.

## Operation
- Notation: in[j] = k[32j +: 32]; out[j] = result[32j +: 32]; Sub() = 4-byte S-box via sub_bytes #(4); Rot(x) = {x[8:31], x[0:7]}; Rcon = 32'h01000000 << (r-1).
- Stage 1 recovers the upper half using a combinational sub_bytes on in[3]:
  - out[4] = in[4] ^ Sub(in[3])
  - out[4+m] = in[4+m] ^ in[3+m], m = 1..3
- Stage 1 register stores {out[4..7], in[0..3], r, valid}.
- Stage 2 recovers the lower half using a second sub_bytes on the registered out[7]:
  - out[0] = in[0] ^ Sub(Rot(out[7])) ^ Rcon
  - out[m] = in[m] ^ in[m-1], m = 1..3
- Stage 2 register drives {result, v_o}.
- Pipeline control:
  - stage-2 load enable: s2_en = !v_o | yumi_i.
  - stage-1 load enable: s1_en = !s1_v | s2_en.
  - ready_o = s1_en.
  - Stalled stages hold data and valid unchanged.
- r outside 1..7 is illegal. Output is don't-care for such r; the pipeline handshake stays correct.
- No FSM beyond the two valid bits. Throughput is one transfer per cycle when yumi_i is held high.

## Timing
- Reset (async assert, sync release): s1_v=0, v_o=0, result=0, stage-1 data=0, ready_o=1.
- Latency: v_i & ready_o at edge N gives v_o=1 with the matching result after edge N+1, i.e. 2 cycles.
- ready_o is combinational from yumi_i. There is no combinational path from v_i to ready_o or v_o.
- Simultaneous events:
  - Stage 2 full and no yumi_i, stage 1 full: ready_o=0 and both stages hold.
  - yumi_i plus a new input on the same edge: both stages advance. No bubble and no drop.
- Reset mid-operation: in-flight data is discarded; v_o falls immediately on reset_n_i low.
- result changes only on a stage-2 load and is stable while v_o & !yumi_i.

## Configuration
- ROUND_KEY_INV_SINGLE_STAGE_EN defined:
  - Stage-1 register removed; both halves are computed combinationally from k.
  - Stage-2 register is the only state. Latency is 1 cycle.
  - ready_o = !v_o | yumi_i.
- Not defined: two-stage pipeline, 2-cycle latency, as above. Port list is identical in both builds.

## Test plan
- Known vector: r=1, k=a573c29f a176c498 a97fce93 a572c09c 1651a8cd 0244beda 1a5da4c1 0640bade -> 2 cycles later v_o=1, result=000102…1e1f (key 00..1f).
- Round trip: for each r=1..7, feed random 256-bit w into the forward round-key block, then feed its output with the same r into this block -> result equals w. Covers Rcon 0x01000000..0x40000000.
- Streaming: v_i=1 and yumi_i=1 for 16 cycles with distinct keys -> ready_o stays 1 and 16 results come out in order, one per cycle, starting at cycle 2.
- Back-pressure: yumi_i=0 while 3 inputs are offered:
  - First two are accepted, then ready_o=0.
  - result holds the first answer.
  - On yumi_i=1 the outputs drain in order with no loss or duplication.
- Reset mid-flight: pull reset_n_i low for 1 cycle while both stages are full -> v_o=0 and result=0 immediately; ready_o=1. The next input yields a correct result 2 cycles later.
- Build with ROUND_KEY_INV_SINGLE_STAGE_EN and rerun the known-vector and back-pressure tests -> identical results with 1-cycle latency and depth-1 buffering.
